// File: rtl/vc_pop_arbiter.sv
// Pops VC0/VC1 round-robin (or VC0 strict priority when VC0_STRICT_PRIO_EN is defined) into D0/D1 by destination bit.
// Pop is combinational from registered state; push follows its pop by exactly one cycle, and almost_full pauses new pops.
module vc_pop_arbiter #(
  parameter int data_width = 6,
  parameter int DEST_BIT   = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [data_width-1:0] vc0_data,
  input  logic [data_width-1:0] vc1_data,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [data_width-1:0] data_out,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      cnt_d0,
  output logic [CNT_W-1:0]      cnt_d1
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t                st;
  logic                  inflight;
  logic                  inflight_vc1;
  logic [data_width-1:0] hold;
  logic                  any_ne;
  logic                  af_any;
  logic                  pop_ok;
  logic                  want0;
  logic                  want1;
  logic                  push_any;
  logic [data_width-1:0] popped;

`ifndef VC0_STRICT_PRIO_EN
  logic                  last_vc1;
`endif

  always_comb begin
    any_ne = !vc0_empty || !vc1_empty;
    af_any = d0_almost_full || d1_almost_full;
    pop_ok = !reset && (st == RUN) && active_in && !af_any;
`ifdef VC0_STRICT_PRIO_EN
    want0 = !vc0_empty;
    want1 = vc0_empty && !vc1_empty;
`else
    // With both VCs ready, serve the one not granted last.
    want0 = !vc0_empty && (vc1_empty || last_vc1);
    want1 = !vc1_empty && (vc0_empty || !last_vc1);
`endif
    vc0_pop = pop_ok && want0;
    vc1_pop = pop_ok && want1;
  end

  // Read data arrives the cycle after the pop, so the word is steered straight from the VC read port.
  always_comb begin
    push_any = inflight && !reset;
    popped   = inflight_vc1 ? vc1_data : vc0_data;
    d0_push  = push_any && !popped[DEST_BIT];
    d1_push  = push_any && popped[DEST_BIT];
    data_out = push_any ? popped : hold;
  end

  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      inflight     <= 1'b0;
      inflight_vc1 <= 1'b0;
      hold         <= '0;
      cnt_d0       <= '0;
      cnt_d1       <= '0;
`ifndef VC0_STRICT_PRIO_EN
      last_vc1     <= 1'b1;
`endif
    end else begin
      inflight     <= vc0_pop || vc1_pop;
      inflight_vc1 <= vc1_pop;
`ifndef VC0_STRICT_PRIO_EN
      if (vc0_pop || vc1_pop)
        last_vc1 <= vc1_pop;
`endif
      if (push_any)
        hold <= popped;
      if (d0_push)
        cnt_d0 <= cnt_d0 + 1'b1;
      if (d1_push)
        cnt_d1 <= cnt_d1 + 1'b1;
      case (st)
        IDLE: begin
          if (active_in && any_ne && !af_any)
            st <= RUN;
        end
        RUN: begin
          if (!active_in || !any_ne)
            st <= IDLE;
          else if (af_any)
            st <= PAUSE;
        end
        PAUSE: begin
          if (!active_in || !any_ne)
            st <= IDLE;
          else if (!af_any)
            st <= RUN;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Scoreboard bench for vc_pop_arbiter: directed VC loads, expected pushes queued, monitor compares at negedge.
module tb_vc_pop_arbiter;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset, active_in, vc0_empty, vc1_empty, d0_af, d1_af;
  logic [DW-1:0] vc0_data, vc1_data;
  logic          vc0_pop, vc1_pop, d0_push, d1_push;
  logic [DW-1:0] data_out;
  logic [1:0]    state;
  logic [7:0]    cnt_d0, cnt_d1;

  vc_pop_arbiter dut (
    .clk(clk), .reset(reset), .active_in(active_in),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_almost_full(d0_af), .d1_almost_full(d1_af),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .d0_push(d0_push), .d1_push(d1_push),
    .data_out(data_out), .state(state),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
  );

  always #5 clk = ~clk;

  typedef struct { logic dest; logic [DW-1:0] dat; } exp_t;
  typedef struct { string name; int act; int exp; } chk_t;

  exp_t          sb[$];
  chk_t          cq[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            errors = 0;
  int            checks = 0;
  int            npop0 = 0, npop1 = 0;
  int            s_pop0, s_pop1, s_state, s_cnt0, s_cnt1, s_dout;

  // Monitor: evaluates queued direct checks and matches every push against the scoreboard.
  always @(negedge clk) begin : mon
    chk_t c;
    exp_t e;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      checks++;
      if (c.act != c.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
      end
    end
    if (reset) begin
      checks++;
      if (d0_push || d1_push || vc0_pop || vc1_pop) begin
        errors++;
        $display("FAIL reset_quiet: got pop=%0b%0b push=%0b%0b expected all 0",
                 vc1_pop, vc0_pop, d1_push, d0_push);
      end
    end else if (d0_push || d1_push) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected: got push d1=%0b data=%h expected no push", d1_push, data_out);
      end else begin
        e = sb.pop_front();
        if ((d0_push && d1_push) || d1_push != e.dest || data_out != e.dat) begin
          errors++;
          $display("FAIL push_data: got d0=%0b d1=%0b data=%h expected d%0d data=%h",
                   d0_push, d1_push, data_out, e.dest, e.dat);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    cq.push_back(c);
  endtask

  // One clock: snapshot outputs mid-cycle, then model the VC FIFOs (data valid the cycle after pop).
  task automatic step();
    @(negedge clk);
    s_pop0 = vc0_pop; s_pop1 = vc1_pop; s_state = state;
    s_cnt0 = cnt_d0;  s_cnt1 = cnt_d1;  s_dout = data_out;
    if (s_pop0 != 0) chk("pop_on_empty_vc0", (q0.size() > 0) ? 1 : 0, 1);
    if (s_pop1 != 0) chk("pop_on_empty_vc1", (q1.size() > 0) ? 1 : 0, 1);
    if (s_pop0 != 0 || s_pop1 != 0) chk("single_pop", s_pop0 + s_pop1, 1);
    @(posedge clk);
    #1;
    if (s_pop0 != 0 && q0.size() > 0) begin vc0_data = q0.pop_front(); npop0++; end
    if (s_pop1 != 0 && q1.size() > 0) begin vc1_data = q1.pop_front(); npop1++; end
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
  endtask

  task automatic load0(input logic [DW-1:0] w);
    q0.push_back(w); vc0_empty = 1'b0;
  endtask

  task automatic load1(input logic [DW-1:0] w);
    q1.push_back(w); vc1_empty = 1'b0;
  endtask

  task automatic expect_w(input logic [DW-1:0] w);
    exp_t e;
    e.dest = w[4]; e.dat = w;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic drain(input int lim, output int n);
    n = 0;
    while ((sb.size() > 0 || q0.size() > 0 || q1.size() > 0) && n < lim) begin
      step(); n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    int n, pc;
    reset = 1'b1; active_in = 1'b1; d0_af = 1'b0; d1_af = 1'b0;
    vc0_data = '0; vc1_data = '0; vc0_empty = 1'b1; vc1_empty = 1'b1;

    // 1: reset held with VC0 non-empty
    load0(6'b110101); expect_w(6'b110101);
    load0(6'b100100); expect_w(6'b100100);
    step(); step();
    chk("rst_state", s_state, 0); chk("rst_pop0", s_pop0, 0);
    chk("rst_cnt0", s_cnt0, 0);   chk("rst_cnt1", s_cnt1, 0);
    chk("rst_dout", s_dout, 0);
    reset = 1'b0;

    // 2: two VC0 words, one to D1 then one to D0
    step(); chk("t2_idle_first", s_state, 0); chk("t2_no_pop_idle", s_pop0, 0);
    step(); chk("t2_pop_a", s_pop0, 1); chk("t2_run", s_state, 1);
    step(); chk("t2_pop_b", s_pop0, 1);
    step(); chk("t2_no_third_pop", s_pop0, 0);
    step();
    chk("t2_back_idle", s_state, 0);
    chk("t2_cnt0", s_cnt0, 1); chk("t2_cnt1", s_cnt1, 1);
    chk("t2_dout_hold", s_dout, 6'b100100);

    // 3: both VCs hold three words
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load0(6'(1 + i));
      load1(6'(6'h31 + i));
    end
`ifdef VC0_STRICT_PRIO_EN
    for (int i = 0; i < 3; i++) expect_w(6'(1 + i));
    for (int i = 0; i < 3; i++) expect_w(6'(6'h31 + i));
`else
    for (int i = 0; i < 3; i++) begin
      expect_w(6'(1 + i));
      expect_w(6'(6'h31 + i));
    end
`endif
    drain(50, n);
    chk("t3_gapless_cycles", n, 8);

    // 4: almost_full the cycle after a pop
    for (int i = 0; i < 4; i++) begin
      load0(6'(5 + i)); expect_w(6'(5 + i));
    end
    step();
    step(); chk("t4_pop_w1", s_pop0, 1);
    d0_af = 1'b1;
    step(); chk("t4_af_blocks_pop", s_pop0, 0);
    step(); chk("t4_pause", s_state, 2);
    pc = npop0;
    step(); step(); step();
    chk("t4_no_pops_paused", npop0, pc); chk("t4_still_pause", s_state, 2);
    d0_af = 1'b0;
    step(); chk("t4_pause_exit_cycle", s_state, 2); chk("t4_pause_exit_nopop", s_pop0, 0);
    step(); chk("t4_resume_run", s_state, 1); chk("t4_resume_pop", s_pop0, 1);
    drain(50, n);

    // 5: active_in drops mid-stream
    for (int i = 0; i < 4; i++) begin
      load1(6'(6'h11 + i)); expect_w(6'(6'h11 + i));
    end
    step(); step();
    step(); chk("t5_pop2", s_pop1, 1);
    active_in = 1'b0;
    step(); chk("t5_no_pop_inactive", s_pop1, 0);
    step(); chk("t5_idle", s_state, 0);
    pc = npop1;
    step(); step(); step();
    chk("t5_no_more_pops", npop1, pc); chk("t5_vc1_left", q1.size(), 2);
    active_in = 1'b1;
    drain(50, n);

    // 6: counter wrap, then reset mid-stream
    do_reset();
    chk("t6_rst_cnt0", s_cnt0, 0); chk("t6_rst_cnt1", s_cnt1, 0);
    for (int i = 0; i < 256; i++) begin
      load0(6'(i % 16)); expect_w(6'(i % 16));
    end
    drain(400, n);
    step();
    chk("t6_cnt0_wrap", s_cnt0, 0); chk("t6_cnt1_zero", s_cnt1, 0);
    chk("t6_dout_last", s_dout, 15);
    for (int i = 0; i < 8; i++) begin
      load1(6'(16 + i)); expect_w(6'(16 + i));
    end
    step(); step(); step(); step();
    reset = 1'b1;
    sb.delete(); q1.delete(); vc1_empty = 1'b1;
    step(); step();
    chk("t6_mid_rst_cnt0", s_cnt0, 0); chk("t6_mid_rst_cnt1", s_cnt1, 0);
    chk("t6_mid_rst_state", s_state, 0);
    reset = 1'b0;
    step(); step();
    chk("t6_post_cnt1", s_cnt1, 0); chk("t6_post_dout", s_dout, 0);

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
